// File: rtl/mips_cpu_mem_stage_if.sv
// Avalon-MM style data bus between the MIPS load/store stage (master) and memory (slave).
interface mips_cpu_mem_stage_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;

  modport master (
    output mem_address, mem_read, mem_write, mem_byteenable, mem_writedata,
    input  mem_readdata, mem_waitrequest
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byteenable, mem_writedata,
    output mem_readdata, mem_waitrequest
  );
endinterface

// File: rtl/mips_cpu_mem_stage.sv
// Multi-cycle MIPS load/store unit: one Avalon-MM read or write per request,
// lane steering for byte/halfword accesses, sign/zero extension of loads.
module mips_cpu_mem_stage (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [5:0]            opcode,
  input  logic [31:0]           alu_result,
  input  logic [31:0]           rt_content,
  mips_cpu_mem_stage_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           load_data,
  output logic                  addr_error
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_NONE = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_in;
  logic        aligned_in;
  logic        mem_op_in;
  logic        accept;

  function automatic logic [1:0] access_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: access_size = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: access_size = SZ_HALF;
      OP_LW, OP_SW:         access_size = SZ_WORD;
      default:              access_size = SZ_NONE;
    endcase
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    is_load = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
              (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_HALF: is_aligned = !a[0];
      SZ_WORD: is_aligned = (a == 2'b00);
      default: is_aligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: byte_enable = 4'b0001 << a;
      SZ_HALF: byte_enable = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: byte_enable = 4'b1111;
      default: byte_enable = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] rt);
    case (size)
      SZ_BYTE: store_data = {4{rt[7:0]}};
      SZ_HALF: store_data = {2{rt[15:0]}};
      default: store_data = rt;
    endcase
  endfunction

  // Lane select then extend; signed locals make the sign extension explicit.
  function automatic logic [31:0] extend_load(input logic [5:0] op, input logic [1:0] lane,
                                              input logic [31:0] rd);
    logic [31:0]        shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    shifted = rd >> {lane, 3'b000};
    b = shifted[7:0];
    h = lane[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_LB:   r = 32'(b);
      OP_LBU:  r = {24'd0, shifted[7:0]};
      OP_LH:   r = 32'(h);
      OP_LHU:  r = {16'd0, h};
      OP_LW:   r = rd;
      default: r = '0;
    endcase
    extend_load = r;
  endfunction

  assign size_in    = access_size(opcode);
  assign aligned_in = is_aligned(size_in, alu_result[1:0]);
  assign mem_op_in  = (size_in != SZ_NONE);
  assign accept     = (state_q == S_IDLE) && start;
  assign busy       = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mem_op_in && aligned_in) state_d = is_load(opcode) ? S_READ : S_WRITE;
          else                         state_d = S_DONE;
        end
      end
      S_READ:  if (!bus.mem_waitrequest) state_d = S_DONE;
      S_WRITE: if (!bus.mem_waitrequest) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch / bus drive stage: everything here is registered off state_d
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_read       <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_byteenable <= '0;
      bus.mem_writedata  <= '0;
      done               <= 1'b0;
      load_data          <= '0;
      addr_error         <= 1'b0;
      op_q               <= '0;
      lane_q             <= '0;
    end else begin
      bus.mem_read  <= (state_d == S_READ);
      bus.mem_write <= (state_d == S_WRITE);
      done          <= (state_d == S_DONE);
      if (accept) begin
        op_q               <= opcode;
        lane_q             <= alu_result[1:0];
        bus.mem_address    <= {alu_result[31:2], 2'b00};
        bus.mem_byteenable <= byte_enable(size_in, alu_result[1:0]);
        bus.mem_writedata  <= store_data(size_in, rt_content);
        load_data          <= '0;
        addr_error         <= mem_op_in && !aligned_in;
      end
      if ((state_q == S_READ) && !bus.mem_waitrequest)
        load_data <= extend_load(op_q, lane_q, bus.mem_readdata);
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_stage.sv
// Bench for mips_cpu_mem_stage: directed scenarios plus randomized requests
// checked against an arithmetic reference model of the load/store rules.
module tb_mips_cpu_mem_stage;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] alu_result;
  logic [31:0] rt_content;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        addr_error;

  int tests = 0;
  int fails = 0;
  logic [3:0]  last_be;
  logic [31:0] last_wd;

  mips_cpu_mem_stage_if bus_if ();

  mips_cpu_mem_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .opcode     (opcode),
    .alu_result (alu_result),
    .rt_content (rt_content),
    .bus        (bus_if.master),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .addr_error (addr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // kind: 0 = no bus cycle, 1 = read, 2 = write
  task automatic ref_model(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                           input logic [31:0] rd, output int kind, output logic [3:0] be,
                           output logic [31:0] wd, output logic [31:0] ld, output logic err);
    longint sz, off, v, lim;
    bit load, sgn;
    case (op)
      6'h20, 6'h24, 6'h28: sz = 1;
      6'h21, 6'h25, 6'h29: sz = 2;
      6'h23, 6'h2B:        sz = 4;
      default:             sz = 0;
    endcase
    load = (op == 6'h20) || (op == 6'h21) || (op == 6'h23) || (op == 6'h24) || (op == 6'h25);
    sgn  = (op == 6'h20) || (op == 6'h21);
    off  = longint'(addr) % 4;
    err  = 1'b0;
    if (sz == 0) kind = 0;
    else if ((longint'(addr) % sz) != 0) begin kind = 0; err = 1'b1; end
    else kind = load ? 1 : 2;
    be = (sz == 0) ? 4'd0 : 4'(((longint'(1) << sz) - 1) << off);
    if (sz == 1)      wd = 32'(longint'(rt[7:0]) * 64'h01010101);
    else if (sz == 2) wd = 32'(longint'(rt[15:0]) * 64'h00010001);
    else              wd = rt;
    ld = '0;
    if (kind == 1) begin
      lim = longint'(1) << (8 * sz);
      v = (longint'(rd) >> (8 * off)) % lim;
      if (sgn && v >= lim / 2) v = v - lim;
      ld = 32'(v);
    end
  endtask

  task automatic run_req(input string tag, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] rt, input logic [31:0] rd, input int waits,
                         input bit poke);
    int kind, done_cyc;
    logic [3:0] ebe;
    logic [31:0] ewd, eld;
    logic eerr;
    ref_model(op, addr, rt, rd, kind, ebe, ewd, eld, eerr);
    done_cyc = (kind == 0) ? 1 : 2 + waits;
    @(negedge clk);
    start = 1'b1; opcode = op; alu_result = addr; rt_content = rt;
    bus_if.mem_waitrequest = 1'b1;
    @(negedge clk);
    opcode = 6'($urandom); alu_result = $urandom; rt_content = $urandom;
    for (int c = 1; c <= done_cyc; c++) begin
      if (c > 1) @(negedge clk);
      start = 1'b0;
      if (c < done_cyc) begin
        check({tag, ":read"},  bus_if.mem_read,  kind == 1);
        check({tag, ":write"}, bus_if.mem_write, kind == 2);
        check({tag, ":addr"},  bus_if.mem_address, {addr[31:2], 2'b00});
        check({tag, ":be"},    bus_if.mem_byteenable, ebe);
        if (kind == 2) check({tag, ":wdata"}, bus_if.mem_writedata, ewd);
        check({tag, ":early_done"}, done, 1'b0);
        if (c == 1) begin last_be = bus_if.mem_byteenable; last_wd = bus_if.mem_writedata; end
        bus_if.mem_waitrequest = (c <= waits);
        bus_if.mem_readdata = bus_if.mem_waitrequest ? $urandom : rd;
        if (poke && c == 2) begin start = 1'b1; opcode = 6'h2B; alu_result = 32'h40; end
      end else begin
        check({tag, ":done"},     done, 1'b1);
        check({tag, ":busy"},     busy, 1'b1);
        check({tag, ":rd_off"},   bus_if.mem_read, 1'b0);
        check({tag, ":wr_off"},   bus_if.mem_write, 1'b0);
        check({tag, ":load"},     load_data, eld);
        check({tag, ":addr_err"}, addr_error, eerr);
      end
    end
    @(negedge clk);
    check({tag, ":done_pulse"}, done, 1'b0);
    check({tag, ":idle"},       busy, 1'b0);
    check({tag, ":quiet"},      {bus_if.mem_read, bus_if.mem_write}, 2'b00);
  endtask

  initial begin
    logic [5:0] ops [10];
    logic [5:0] rop;
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h09, 6'h00};
    rst_n = 1'b0; start = 1'b0; opcode = '0; alu_result = '0; rt_content = '0;
    bus_if.mem_readdata = '0; bus_if.mem_waitrequest = 1'b0;
    #1;
    check("reset:busy", busy, 1'b0);
    check("reset:done", done, 1'b0);
    check("reset:strobes", {bus_if.mem_read, bus_if.mem_write}, 2'b00);
    check("reset:load", load_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_req("sw", 6'h2B, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b0);
    check("sw:be_const", last_be, 4'b1111);
    check("sw:wd_const", last_wd, 32'hDEADBEEF);
    run_req("sb", 6'h28, 32'h103, 32'h000000A5, 32'h0, 0, 1'b0);
    check("sb:be_const", last_be, 4'b1000);
    check("sb:wd_const", last_wd, 32'hA5A5A5A5);
    run_req("sh", 6'h29, 32'h106, 32'h1234BEEF, 32'h0, 1, 1'b0);
    check("sh:wd_const", last_wd, 32'hBEEFBEEF);

    run_req("lb201", 6'h20, 32'h201, 32'h0, 32'h80FF7F01, 0, 1'b0);
    check("lb201:const", load_data, 32'h0000007F);
    run_req("lbu201", 6'h24, 32'h201, 32'h0, 32'h80FF7F01, 0, 1'b0);
    check("lbu201:const", load_data, 32'h0000007F);
    run_req("lb202", 6'h20, 32'h202, 32'h0, 32'h80FF7F01, 0, 1'b0);
    check("lb202:const", load_data, 32'hFFFFFFFF);
    run_req("lbu202", 6'h24, 32'h202, 32'h0, 32'h80FF7F01, 0, 1'b0);
    check("lbu202:const", load_data, 32'h000000FF);
    run_req("lh", 6'h21, 32'h202, 32'h0, 32'h80FF7F01, 0, 1'b0);
    check("lh:const", load_data, 32'hFFFF80FF);
    run_req("lhu", 6'h25, 32'h202, 32'h0, 32'h80FF7F01, 0, 1'b0);
    check("lhu:const", load_data, 32'h000080FF);
    run_req("lb203", 6'h20, 32'h203, 32'h0, 32'h80FF7F01, 0, 1'b0);
    check("lb203:const", load_data, 32'hFFFFFF80);

    run_req("lw_wait", 6'h23, 32'h3F0, 32'h0, 32'hCAFEF00D, 3, 1'b1);
    check("lw_wait:const", load_data, 32'hCAFEF00D);

    run_req("mis_lw", 6'h23, 32'h101, 32'h0, 32'h0, 0, 1'b0);
    run_req("mis_lh", 6'h21, 32'h301, 32'h0, 32'h0, 0, 1'b0);
    check("mis_lh:const", {31'd0, addr_error}, 32'd1);
    run_req("op09", 6'h09, 32'h100, 32'h0, 32'h0, 0, 1'b0);

    // Reset while a read is stalled on waitrequest
    @(negedge clk);
    start = 1'b1; opcode = 6'h23; alu_result = 32'h400;
    @(negedge clk);
    start = 1'b0; bus_if.mem_waitrequest = 1'b1;
    check("rst:read_on", bus_if.mem_read, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst:read_off", bus_if.mem_read, 1'b0);
    check("rst:busy", busy, 1'b0);
    check("rst:addr", bus_if.mem_address, 32'h0);
    check("rst:be", bus_if.mem_byteenable, 4'h0);
    check("rst:wd", bus_if.mem_writedata, 32'h0);
    check("rst:misc", {done, addr_error, bus_if.mem_write}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1; bus_if.mem_waitrequest = 1'b0;
    run_req("sw_after_rst", 6'h2B, 32'h80, 32'h01234567, 32'h0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = (i % 7 == 6) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      run_req($sformatf("rnd%0d", i), rop, $urandom, $urandom, $urandom,
              int'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
